cfg_pass_scheduler: RTL

//  Top-level sequencer for sensor configuration. Runs the row config engine, then the column config engine.

---
 rtl/cfg_pass_scheduler_pkg.sv | 25 ++
 rtl/cfg_pass_scheduler_wdt.sv | 31 +++
 rtl/cfg_pass_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cfg_pass_scheduler_pkg.sv
// Shared state encoding and default sizing for the config pass scheduler.
// Latency: none (types and constants only).
// Backpressure: none.
package cfg_pass_scheduler_pkg;

    localparam int DEF_PASS_W         = 8;
    localparam int DEF_WDT_W          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ROW_GO   = 3'd1,
        ST_ROW_WAIT = 3'd2,
        ST_COL_GO   = 3'd3,
        ST_COL_WAIT = 3'd4,
        ST_PASS_CHK = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } state_t;

    function automatic logic is_busy(state_t s);
        return !(s == ST_IDLE || s == ST_DONE || s == ST_ERROR);
    endfunction

endpackage

// File: rtl/cfg_pass_scheduler_wdt.sv
// Wait-state watchdog: clears on entry, counts while enabled, flags the last allowed cycle.
// Latency: o_timeout is combinational on the registered count.
// Backpressure: none; i_clr has priority over i_en.
module cfg_pass_scheduler_wdt #(
    parameter int WDT_W          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [WDT_W-1:0] LP_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

    logic [WDT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + WDT_W'(1);
        end
    end

    assign o_timeout = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/cfg_pass_scheduler.sv
// Sequences row then column config engines for N passes, with sticky abort (optional watchdog: CFG_SCHED_WDT_EN).
// Latency: start->row go 1 cycle, row done->col go 1 cycle, col done->next row go 2 cycles.
// Backpressure: engines are never stopped; abort is honoured at the running engine's done.
module cfg_pass_scheduler
    import cfg_pass_scheduler_pkg::*;
#(
    parameter int PASS_W         = DEF_PASS_W,
    parameter int WDT_W          = DEF_WDT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [PASS_W-1:0] i_passes,
    output logic              o_row_go,
    input  logic              i_row_done,
    output logic              o_col_go,
    input  logic              i_col_done,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic              o_err,
    output logic [PASS_W-1:0] o_pass_cnt
);

    state_t            r_state;
    state_t            w_next;
    logic [PASS_W-1:0] r_passes;
    logic [PASS_W-1:0] r_pass_cnt;
    logic              r_abort;
    logic              w_start_ok;
    logic              w_last;
    logic              w_wdt_timeout;

    assign w_start_ok = i_start && (r_state == ST_IDLE || r_state == ST_ERROR);
    assign w_last     = (r_pass_cnt + PASS_W'(1)) == r_passes;

`ifdef CFG_SCHED_WDT_EN
    logic w_wdt_clr;
    logic w_wdt_en;

    // Each go state is the single entry point of its wait state.
    assign w_wdt_clr = (r_state == ST_ROW_GO) || (r_state == ST_COL_GO);
    assign w_wdt_en  = (r_state == ST_ROW_WAIT) || (r_state == ST_COL_WAIT);

    cfg_pass_scheduler_wdt #(
        .WDT_W         (WDT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_wdt_clr),
        .i_en     (w_wdt_en),
        .o_timeout(w_wdt_timeout)
    );
`else
    assign w_wdt_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (i_start) begin
                    w_next = (i_passes == '0) ? ST_DONE : ST_ROW_GO;
                end
            end
            ST_ROW_GO:   w_next = ST_ROW_WAIT;
            ST_ROW_WAIT: begin
                if (i_row_done) begin
                    w_next = (r_abort || i_abort) ? ST_DONE : ST_COL_GO;
                end else if (w_wdt_timeout) begin
                    w_next = ST_ERROR;
                end
            end
            ST_COL_GO:   w_next = ST_COL_WAIT;
            ST_COL_WAIT: begin
                if (i_col_done) begin
                    w_next = ST_PASS_CHK;
                end else if (w_wdt_timeout) begin
                    w_next = ST_ERROR;
                end
            end
            ST_PASS_CHK: w_next = (r_abort || w_last) ? ST_DONE : ST_ROW_GO;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_passes   <= '0;
            r_pass_cnt <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_passes   <= i_passes;
                r_pass_cnt <= '0;
                r_abort    <= 1'b0;
            end else begin
                if (is_busy(r_state) && i_abort) begin
                    r_abort <= 1'b1;
                end
                // Stops at r_passes because PASS_CHK exits to DONE on the last pass.
                if (r_state == ST_PASS_CHK) begin
                    r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                end
            end
        end
    end

    assign o_row_go   = (r_state == ST_ROW_GO);
    assign o_col_go   = (r_state == ST_COL_GO);
    assign o_busy     = is_busy(r_state);
    assign o_done     = (r_state == ST_DONE);
    assign o_aborted  = (r_state == ST_DONE) && r_abort;
    assign o_err      = (r_state == ST_ERROR);
    assign o_pass_cnt = r_pass_cnt;

endmodule
